// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, hazard stall, flush
// and an optional second (skid) entry. The control field is kept apart from
// the payload so that a flush or an empty stage always presents all-zero
// control bits downstream, while the payload is left untouched.
module pipe_stage_reg #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 143,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    BOTH  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              accept;
  logic              consume;
  logic              load_main_in;
  logic              load_main_skid;
  logic              clear_main_ctrl;
  logic              load_skid;
  logic              clear_skid;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  // Handshake readiness: the skid variant looks only at registered state so
  // in_ready never depends on out_ready; the single-entry variant may refill
  // in the same cycle it is drained.
  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = ~stall & (state != BOTH);
    end else begin
      in_ready = ~stall & (~out_valid | out_ready);
    end
  end

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready & ~stall;

  // Occupancy is reported straight from the state, one entry per held slot.
  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      MAIN:    occupancy = 2'd1;
      BOTH:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and register-load decisions; flush beats stall, which beats
  // any transfer. Whenever the stage drains, the main control field is
  // cleared so a bubble never carries live control bits.
  always_comb begin
    state_next      = state;
    load_main_in    = 1'b0;
    load_main_skid  = 1'b0;
    clear_main_ctrl = 1'b0;
    load_skid       = 1'b0;
    clear_skid      = 1'b0;
    if (flush) begin
      state_next      = EMPTY;
      clear_main_ctrl = 1'b1;
      clear_skid      = 1'b1;
    end else if (!stall) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = MAIN;
            load_main_in = 1'b1;
          end
        end
        MAIN: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (consume) begin
            state_next      = EMPTY;
            clear_main_ctrl = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_next = BOTH;
            load_skid  = 1'b1;
          end
        end
        BOTH: begin
          if (consume) begin
            state_next     = MAIN;
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
          end
        end
        default: begin
          state_next      = EMPTY;
          clear_main_ctrl = 1'b1;
          clear_skid      = 1'b1;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Main (output) entry: loads from the input or promotes the skid entry;
  // the payload is retained when the stage empties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end else if (clear_main_ctrl) begin
      main_ctrl <= '0;
    end
  end

  // Skid entry: catches the one extra beat accepted while main is blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (clear_skid) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

endmodule
